// File: rtl/registered_demultiplexer.sv
// Registered 1-to-4 demultiplexer: one holding register per lane with valid/ready handshake.
// Optional per-lane saturating delivered-word counters are enabled with DEMUX_COUNT_EN.
`timescale 1ns/1ps

module registered_demultiplexer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             addr0,
  input  logic             addr1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
`endif
);

  localparam int LANES = 4;

  logic [1:0]       lane_sel;
  logic [LANES-1:0] out_ready;
  logic [LANES-1:0] full_q, full_d;
  logic [LANES-1:0] load, drain;
  logic [WIDTH-1:0] data_q [LANES];
  logic [WIDTH-1:0] data_d [LANES];
  logic             accept;

  assign lane_sel  = {addr1, addr0};
  assign out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

  // Only the addressed lane gates the input; a stalled lane never blocks the others.
  assign in_ready = !full_q[lane_sel] || out_ready[lane_sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before any conditional, so no latch is inferred.
    load  = '0;
    drain = '0;
    for (int k = 0; k < LANES; k++) begin
      data_d[k] = data_q[k];
      drain[k]  = full_q[k] && out_ready[k];
      load[k]   = accept && (lane_sel == 2'(k));
      if (load[k]) data_d[k] = in;
    end
    // A load wins over a same-edge drain, giving one word per cycle per lane.
    full_d = load | (full_q & ~drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset too, since outK must read 0 out of reset.
    if (!rst_n) begin
      full_q <= '0;
      for (int k = 0; k < LANES; k++) data_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      full_q <= full_d;
      for (int k = 0; k < LANES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out0 = data_q[0];
  assign out1 = data_q[1];
  assign out2 = data_q[2];
  assign out3 = data_q[3];

  assign out0_valid = full_q[0];
  assign out1_valid = full_q[1];
  assign out2_valid = full_q[2];
  assign out3_valid = full_q[3];

`ifdef DEMUX_COUNT_EN
  logic [7:0] cnt_q [LANES];
  logic [7:0] cnt_d [LANES];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      cnt_d[k] = cnt_q[k];
      if (drain[k] && (cnt_q[k] != 8'hFF)) cnt_d[k] = cnt_q[k] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule
